uart_rx: RTL and testbench

//   8N1 UART receiver; the return path to the host for uart_tx.

---
 rtl/uart_pkg.sv | 18 +
 rtl/bit_synchronizer.sv | 29 ++
 rtl/uart_rx.sv | 164 ++++++++++++++++
 tb/tb_uart_rx.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and the bit-vote helper.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit; reset value is a parameter so
// an idle-high line does not look like an edge when reset is released.
module bit_synchronizer #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  if (STAGES < 2) begin : g_bad_stages
    $error("bit_synchronizer: STAGES must be >= 2");
  end

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronized input, three-sample majority vote per bit,
// valid/ready byte output with framing, break and sticky overrun reporting.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 15,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      uart_rx_i,
  output logic [UART_DATA_BITS-1:0] data_o,
  output logic                      data_valid_o,
  input  logic                      data_ready_i,
  output logic                      framing_error_o,
  output logic                      break_o,
  output logic                      overrun_o,
  input  logic                      overrun_clear_i,
  output logic                      busy_o,
  output rx_state_t                 state_o
);

  if (CLKS_PER_BIT < 6) begin : g_bad_cpb
    $error("uart_rx: CLKS_PER_BIT must be >= 6");
  end

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam int MID   = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SAMP_0   = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] SAMP_1   = CNT_W'(MID);
  localparam logic [CNT_W-1:0] VOTE_AT  = CNT_W'(MID + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  rx_state_t                 state_q, state_d;
  logic                      rx_s;
  logic                      rx_prev_q;
  logic                      fall;
  logic [CNT_W-1:0]          bit_cnt_q;
  logic [IDX_W-1:0]          bit_idx_q;
  logic [1:0]                samp_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      cnt_last;
  logic                      at_vote;
  logic                      vote;
  logic                      shift_en;
  logic                      byte_done;
  logic                      frame_bad;

  bit_synchronizer #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .d_i    (uart_rx_i),
    .q_o    (rx_s)
  );

  assign fall     = ~rx_s & rx_prev_q;
  assign cnt_last = (bit_cnt_q == CNT_LAST);
  assign at_vote  = (bit_cnt_q == VOTE_AT);
  // Two stored samples plus the live one form the third sample at MID+1.
  assign vote     = majority3(samp_q[0], samp_q[1], rx_s);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= WAIT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_IDLE: if (rx_s) state_d = IDLE;
      IDLE:      if (fall) state_d = START;
      START: begin
        if (at_vote && vote) begin
          state_d = IDLE;
        end else if (cnt_last) begin
          state_d = DATA;
        end
      end
      DATA:      if (cnt_last && (bit_idx_q == IDX_LAST)) state_d = STOP;
      STOP:      if (at_vote) state_d = vote ? IDLE : WAIT_IDLE;
      default:   state_d = WAIT_IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state_q != IDLE);
    shift_en  = (state_q == DATA) && at_vote;
    byte_done = (state_q == STOP) && at_vote && vote;
    frame_bad = (state_q == STOP) && at_vote && !vote;
  end

  assign state_o = state_q;

  // Counter is parked at 0 outside a frame so the first START cycle sees cnt=0.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_prev_q <= 1'b1;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      samp_q    <= 2'b11;
      shift_q   <= '0;
    end else begin
      rx_prev_q <= rx_s;

      if ((state_q == IDLE) || (state_q == WAIT_IDLE) || cnt_last) begin
        bit_cnt_q <= '0;
      end else begin
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end

      if (state_q != DATA) begin
        bit_idx_q <= '0;
      end else if (cnt_last) begin
        bit_idx_q <= bit_idx_q + IDX_W'(1);
      end

      if (bit_cnt_q == SAMP_0) samp_q[0] <= rx_s;
      if (bit_cnt_q == SAMP_1) samp_q[1] <= rx_s;

      if (shift_en) begin
        shift_q <= {vote, shift_q[UART_DATA_BITS-1:1]};
      end
    end
  end

  // Handshake: data_valid_o rises when a byte loads and stays high, with data_o stable,
  // until a cycle with data_valid_o && data_ready_i; a load in that same cycle keeps it
  // high with the new byte. A load while valid and not ready overwrites data_o and sets overrun.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_o          <= '0;
      data_valid_o    <= 1'b0;
      framing_error_o <= 1'b0;
      break_o         <= 1'b0;
      overrun_o       <= 1'b0;
    end else begin
      framing_error_o <= frame_bad;
      break_o         <= frame_bad && (shift_q == '0);

      if (byte_done) begin
        data_o       <= shift_q;
        data_valid_o <= 1'b1;
      end else if (data_valid_o && data_ready_i) begin
        data_valid_o <= 1'b0;
      end

      if (byte_done && data_valid_o && !data_ready_i) begin
        overrun_o <= 1'b1;
      end else if (overrun_clear_i) begin
        overrun_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serializer-driven frames, a negedge monitor feeding a byte
// scoreboard, and pulse counters compared against frame-level expectations.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 15;
  localparam int MID = CPB / 2;
  localparam int LAT = 3 + 9 * CPB + MID + 2;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       uart_rx_i;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       data_ready_i;
  logic       framing_error_o;
  logic       break_o;
  logic       overrun_o;
  logic       overrun_clear_i;
  logic       busy_o;
  rx_state_t  state_o;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  int         acc_cnt = 0;
  int         fe_cnt = 0;
  int         brk_cnt = 0;
  int         spurious_cnt = 0;
  logic       fe_prev = 1'b0;
  bit         rand_ready = 1'b0;
  int         a0, f0, b0;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .uart_rx_i      (uart_rx_i),
    .data_o         (data_o),
    .data_valid_o   (data_valid_o),
    .data_ready_i   (data_ready_i),
    .framing_error_o(framing_error_o),
    .break_o        (break_o),
    .overrun_o      (overrun_o),
    .overrun_clear_i(overrun_clear_i),
    .busy_o         (busy_o),
    .state_o        (state_o)
  );

  // clock
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (data_valid_o && data_ready_i) begin
        acc_cnt++;
        if (exp_q.size() > 0) chk("rx_byte", 32'(data_o), 32'(exp_q.pop_front()));
        else spurious_cnt++;
      end
      if (framing_error_o) begin
        fe_cnt++;
        chk("fe_one_cycle", 32'(fe_prev), 0);
      end
      if (break_o) begin
        brk_cnt++;
        chk("break_with_fe", 32'(framing_error_o), 1);
      end
    end
    fe_prev = framing_error_o;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_bit(input logic b);
    uart_rx_i = b;
    for (int i = 0; i < CPB; i++) begin
      if (rand_ready) data_ready_i = ($urandom_range(0, 3) != 0);
      tick(1);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    uart_rx_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (rand_ready) data_ready_i = ($urandom_range(0, 3) != 0);
      tick(1);
    end
  endtask

  task automatic mark();
    a0 = acc_cnt;
    f0 = fe_cnt;
    b0 = brk_cnt;
  endtask

  initial begin
    logic [7:0] d;
    logic       good;
    int         gap, n_good, n_fe, n_brk;

    // reset
    reset_i = 1'b1; uart_rx_i = 1'b1; data_ready_i = 1'b0; overrun_clear_i = 1'b0;
    tick(3);
    chk("rst_data", 32'(data_o), 0);
    chk("rst_valid", 32'(data_valid_o), 0);
    chk("rst_fe", 32'(framing_error_o), 0);
    chk("rst_break", 32'(break_o), 0);
    chk("rst_overrun", 32'(overrun_o), 0);
    chk("rst_busy", 32'(busy_o), 1);
    reset_i = 1'b0;
    tick(4);
    chk("idle_busy", 32'(busy_o), 0);

    // 1: latency and hold with ready low
    mark();
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (LAT - 1) @(posedge clk_i);
        #1 chk("t1_valid_before_lat", 32'(data_valid_o), 0);
        @(posedge clk_i);
        #1 chk("t1_valid_at_lat", 32'(data_valid_o), 1);
        chk("t1_data_at_lat", 32'(data_o), 32'h A5);
      end
    join
    tick(20);
    chk("t1_valid_held", 32'(data_valid_o), 1);
    chk("t1_data_held", 32'(data_o), 32'h A5);
    data_ready_i = 1'b1;
    tick(1);
    chk("t1_valid_cleared", 32'(data_valid_o), 0);
    chk("t1_accepted", 32'(acc_cnt - a0), 1);

    // 2: back-to-back frames, ready high
    mark();
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    idle(2 * CPB);
    chk("t2_accepted", 32'(acc_cnt - a0), 3);
    chk("t2_queue_empty", 32'(exp_q.size()), 0);
    chk("t2_no_fe", 32'(fe_cnt - f0), 0);

    // 3: short low glitch rejected
    mark();
    uart_rx_i = 1'b0;
    tick(5);
    idle(2 * CPB);
    chk("t3_busy_after_glitch", 32'(busy_o), 0);
    chk("t3_no_byte_glitch", 32'(acc_cnt - a0), 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle(2 * CPB);
    chk("t3_accepted", 32'(acc_cnt - a0), 1);
    chk("t3_no_fe", 32'(fe_cnt - f0), 0);

    // 4: bad stop bit
    mark();
    send_frame(8'h81, 1'b0);
    idle(2 * CPB);
    chk("t4_fe", 32'(fe_cnt - f0), 1);
    chk("t4_no_break", 32'(brk_cnt - b0), 0);
    chk("t4_no_byte", 32'(acc_cnt - a0), 0);

    // 4b: line held low for 20 bit times
    mark();
    uart_rx_i = 1'b0;
    tick(20 * CPB);
    chk("t4b_busy_low", 32'(busy_o), 1);
    idle(2 * CPB);
    chk("t4b_fe", 32'(fe_cnt - f0), 1);
    chk("t4b_break", 32'(brk_cnt - b0), 1);
    chk("t4b_no_byte", 32'(acc_cnt - a0), 0);

    // 4c: recovery
    mark();
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    idle(2 * CPB);
    chk("t4c_accepted", 32'(acc_cnt - a0), 1);

    // 5: overrun
    mark();
    data_ready_i = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(5);
    chk("t5_overrun", 32'(overrun_o), 1);
    chk("t5_data", 32'(data_o), 32'h22);
    chk("t5_valid", 32'(data_valid_o), 1);

    // 5b: clear coincident with a new overrun
    fork
      send_frame(8'h33, 1'b1);
      begin
        repeat (LAT - 1) @(posedge clk_i);
        #1 overrun_clear_i = 1'b1;
        @(posedge clk_i);
        #1 overrun_clear_i = 1'b0;
        chk("t5b_overrun_kept", 32'(overrun_o), 1);
        chk("t5b_data", 32'(data_o), 32'h33);
      end
    join

    // 5c: clear alone
    tick(10);
    overrun_clear_i = 1'b1;
    tick(1);
    overrun_clear_i = 1'b0;
    chk("t5c_overrun_cleared", 32'(overrun_o), 0);
    exp_q.push_back(8'h33);
    data_ready_i = 1'b1;
    tick(2);
    chk("t5_accepted", 32'(acc_cnt - a0), 1);
    chk("t5_valid_cleared", 32'(data_valid_o), 0);

    // 6: reset during DATA with the line low at release
    mark();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    reset_i = 1'b1;
    tick(3);
    reset_i = 1'b0;
    chk("t6_busy_at_release", 32'(busy_o), 1);
    chk("t6_valid_at_release", 32'(data_valid_o), 0);
    tick(3);
    idle(CPB);
    chk("t6_no_fe", 32'(fe_cnt - f0), 0);
    chk("t6_no_break", 32'(brk_cnt - b0), 0);
    chk("t6_no_byte", 32'(acc_cnt - a0), 0);
    chk("t6_busy_idle", 32'(busy_o), 0);

    // 6b: recovery after reset
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    idle(2 * CPB);
    chk("t6b_accepted", 32'(acc_cnt - a0), 1);

    // 7: random frames, gaps, stop errors and ready
    mark();
    n_good = 0; n_fe = 0; n_brk = 0;
    rand_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d    = 8'($urandom_range(0, 255));
      if (i == 5) d = 8'h00;
      good = ($urandom_range(0, 4) != 0);
      if (good) begin
        exp_q.push_back(d);
        n_good++;
      end else begin
        n_fe++;
        if (d == 8'h00) n_brk++;
      end
      send_frame(d, good);
      gap = good ? $urandom_range(0, 2 * CPB) : $urandom_range(CPB, 2 * CPB);
      idle(gap);
    end
    rand_ready = 1'b0;
    data_ready_i = 1'b1;
    idle(3 * CPB);
    chk("t7_accepted", 32'(acc_cnt - a0), 32'(n_good));
    chk("t7_queue_empty", 32'(exp_q.size()), 0);
    chk("t7_fe", 32'(fe_cnt - f0), 32'(n_fe));
    chk("t7_break", 32'(brk_cnt - b0), 32'(n_brk));
    chk("t7_no_overrun", 32'(overrun_o), 0);

    chk("spurious_bytes", 32'(spurious_cnt), 0);

    // report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
